// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD complement datapath.
package bcd_pkg;

    localparam int               BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    localparam logic NINES = 1'b0;
    localparam logic TENS  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Digit index needs at least one bit even for a single-digit build.
    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_complement.sv
// One-digit combinational complement cell: r = (9 - d) + carry_in, with
// a decimal carry at r = 10 and an invalid flag for non-BCD digits.
module bcd_digit_complement
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    input  logic             carry_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             carry_o,
    output logic             invalid_o
);

    logic [BCD_W:0] sum;

    // NOTE: every output gets a default before the conditionals, so no latch can be inferred.
    always_comb begin
        sum       = {1'b0, BCD_MAX - digit_i} + {{BCD_W{1'b0}}, carry_i};
        invalid_o = (digit_i > BCD_MAX);
        digit_o   = sum[BCD_W-1:0];
        carry_o   = 1'b0;
        if (invalid_o) begin
            digit_o = '0;
        end else if (sum == (BCD_W+1)'(10)) begin
            digit_o = '0;
            carry_o = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_complement_serial.sv
// Digit-serial nine's/ten's BCD complementer with valid/ready handshakes;
// one digit per clock, least significant first, carry rippled through a register.
module bcd_complement_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BCD_W*DIGITS-1:0] in_data,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BCD_W*DIGITS-1:0] out_data,
    output logic                  out_carry,
    output logic                  out_err
);

    localparam int               W        = BCD_W * DIGITS;
    localparam int               IDX_W    = idx_width(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     operand_q, operand_d;
    logic [W-1:0]     result_q, result_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [BCD_W-1:0] cur_digit;
    logic [BCD_W-1:0] cell_digit;
    logic             cell_carry;
    logic             cell_invalid;

    assign cur_digit = operand_q[int'(idx_q)*BCD_W +: BCD_W];

    bcd_digit_complement u_cell (
        .digit_i   (cur_digit),
        .carry_i   (carry_q),
        .digit_o   (cell_digit),
        .carry_o   (cell_carry),
        .invalid_o (cell_invalid)
    );

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        result_d  = result_q;
        mode_d    = mode_q;
        carry_d   = carry_q;
        err_d     = err_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    operand_d = in_data;
                    mode_d    = in_mode;
                    carry_d   = in_mode;
                    err_d     = 1'b0;
                    idx_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                result_d[int'(idx_q)*BCD_W +: BCD_W] = cell_digit;
                carry_d = cell_carry;
                if (cell_invalid) begin
                    err_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            operand_q <= '0;
            result_q  <= '0;
            mode_q    <= NINES;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            mode_q    <= mode_d;
            carry_q   <= carry_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
        end
    end

    // Handshake outputs decode registered state only; out_ready never reaches in_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = result_q;
    assign out_carry = carry_q & (mode_q == TENS);
    assign out_err   = err_q;

endmodule
